event_encoder: RTL

//  Inverse of the 5-to-32 registered decoder: collects up to N one-hot/multi-hot

---
 rtl/event_encoder_pkg.sv | 15 +
 rtl/event_encoder_if.sv | 15 +
 rtl/event_encoder_prio_enc.sv | 23 ++
 rtl/event_encoder.sv | 64 ++++++
 4 files changed

// File: rtl/event_encoder_pkg.sv
// Shared constants and helpers for the event encoder slice.
package event_encoder_pkg;

    localparam int EVT_N = 32;
    localparam int EVT_W = 5;

    // One-hot mask for an index; callers with N < EVT_N truncate the result.
    function automatic logic [EVT_N-1:0] onehot(input logic [EVT_W-1:0] i);
        logic [EVT_N-1:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/event_encoder_if.sv
// Request input and indexed-event output handshake of the encoder.
interface event_encoder_if import event_encoder_pkg::*; #(
    parameter int N = EVT_N,
    parameter int W = EVT_W
) ();
    logic [N-1:0] req;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         merged;
    logic         busy;

    modport master (input req, out_ready, output out_idx, out_valid, merged, busy);
    modport slave  (output req, out_ready, input out_idx, out_valid, merged, busy);
endinterface

// File: rtl/event_encoder_prio_enc.sv
// Lowest-index-wins priority encoder, purely combinational.
module prio_enc #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top so the last hit, the lowest set bit, wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_encoder.sv
// Sticky pending set of event requests drained one index at a time,
// lowest index first, through a registered valid/ready output.
// N is limited to EVT_N because the shared onehot helper is EVT_N wide.
module event_encoder import event_encoder_pkg::*; #(
    parameter int N = EVT_N,
    parameter int W = EVT_W
) (
    input logic             clk,
    input logic             rst,
    event_encoder_if.master bus
);

    logic [N-1:0] pending, cand, pending_nxt;
    logic [W-1:0] sel, idx_q;
    logic         any, vld_q, vld_nxt, merged_q, busy_q;
    logic         pop, load;

    // New requests join the pending set before selection, giving the
    // single-cycle latency from an idle output.
    assign cand = pending | bus.req;

    prio_enc #(.N(N), .W(W)) u_prio (
        .vec (cand),
        .idx (sel),
        .any (any)
    );

    assign pop  = vld_q & bus.out_ready;
    assign load = ~vld_q | pop;

    // Next pending set and output valid; the offered index leaves pending
    // when loaded, so a fresh request for it re-fires instead of merging.
    always_comb begin
        pending_nxt = cand;
        vld_nxt     = vld_q;
        if (load) begin
            vld_nxt     = any;
            pending_nxt = any ? (cand & ~N'(onehot(EVT_W'(sel)))) : '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            vld_q    <= 1'b0;
            idx_q    <= '0;
            merged_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            vld_q    <= vld_nxt;
            if (load && any) idx_q <= sel;
            merged_q <= |(bus.req & pending);
            busy_q   <= (|pending_nxt) | vld_nxt;
        end
    end

    assign bus.out_idx   = idx_q;
    assign bus.out_valid = vld_q;
    assign bus.merged    = merged_q;
    assign bus.busy      = busy_q;

endmodule
